// File: rtl/sm4_pkg.sv
// SM4 key-schedule constants: FK, CK, S-box, FSM state encodings, round count.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sm4_pkg;

    localparam int unsigned ROUNDS   = 32;
    localparam logic [4:0]  LAST_RND = 5'(ROUNDS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ROUND = 1'b1;

    localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

    // Byte j of CK_i is (4i+j)*7 mod 256, byte 0 in the MSBs.
    localparam logic [31:0] CK [32] = '{
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

endpackage

// File: rtl/transform_for_key_exp.sv
// Key-expansion T' transform: byte-wise S-box then x ^ (x<<<13) ^ (x<<<23).
// Latency: combinational.
// Backpressure: none.
// Ports: din_i (32-bit word into the S-boxes), dout_o (transformed word).
module transform_for_key_exp
    import sm4_pkg::*;
(
    input  logic [31:0] din_i,
    output logic [31:0] dout_o
);

    logic [31:0] b;

    assign b = {SBOX[din_i[31:24]], SBOX[din_i[23:16]], SBOX[din_i[15:8]], SBOX[din_i[7:0]]};

    assign dout_o = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

endmodule

// File: rtl/sm4_key_sched.sv
// SM4 key schedule: accepts a 128-bit master key, emits 32 round keys, one per cycle.
// Latency: rk_i strobes 2+i cycles after key acceptance; done_o with rk_31; ready again with done_o.
// Backpressure: key_ready_o low while rounds run; the rk stream cannot be stalled.
//
// Ports: clk_i/rst_ni (async active-low), clear_i (sync flush, top priority),
//   key_valid_i/key_ready_o/key_i (master key handshake, MK0 in [127:96]),
//   busy_o (rounds in progress), rk_valid_o/rk_idx_o/rk_o (round-key strobe), done_o (last key).
// Build option SM4_KS_RK_STORE_EN: adds 32x32 key storage with combinational read
//   port rd_idx_i/rd_rk_o and keys_valid_o (storage holds the last completed schedule).
module sm4_key_sched
    import sm4_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [127:0] key_i,
`ifdef SM4_KS_RK_STORE_EN
    input  logic [4:0]   rd_idx_i,
    output logic [31:0]  rd_rk_o,
    output logic         keys_valid_o,
`endif
    output logic         busy_o,
    output logic         rk_valid_o,
    output logic [4:0]   rk_idx_o,
    output logic [31:0]  rk_o,
    output logic         done_o
);

    logic [0:0]  state;
    logic [4:0]  cnt;
    logic [31:0] k0, k1, k2, k3;
    logic [31:0] t_in, t_out, rk_next;
    logic        accept;

    assign key_ready_o = (state == ST_IDLE);
    assign busy_o      = (state == ST_ROUND);
    assign accept      = key_ready_o && key_valid_i && !clear_i;

    assign t_in    = k1 ^ k2 ^ k3 ^ CK[cnt];
    assign rk_next = k0 ^ t_out;

    transform_for_key_exp u_tkey (
        .din_i  (t_in),
        .dout_o (t_out)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            k0         <= '0;
            k1         <= '0;
            k2         <= '0;
            k3         <= '0;
            rk_o       <= '0;
            rk_idx_o   <= '0;
            rk_valid_o <= 1'b0;
            done_o     <= 1'b0;
        end else if (clear_i) begin
            // rk_o, rk_idx_o and the K registers are left as they are.
            state      <= ST_IDLE;
            cnt        <= '0;
            rk_valid_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            rk_valid_o <= 1'b0;
            done_o     <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept) begin
                    k0    <= key_i[127:96] ^ FK[0];
                    k1    <= key_i[95:64]  ^ FK[1];
                    k2    <= key_i[63:32]  ^ FK[2];
                    k3    <= key_i[31:0]   ^ FK[3];
                    cnt   <= '0;
                    state <= ST_ROUND;
                end
            end else begin
                k0         <= k1;
                k1         <= k2;
                k2         <= k3;
                k3         <= rk_next;
                rk_o       <= rk_next;
                rk_idx_o   <= cnt;
                rk_valid_o <= 1'b1;
                if (cnt == LAST_RND) begin
                    // Leave ROUND instead of letting the counter wrap.
                    done_o <= 1'b1;
                    cnt    <= '0;
                    state  <= ST_IDLE;
                end else begin
                    cnt <= cnt + 5'd1;
                end
            end
        end
    end

`ifdef SM4_KS_RK_STORE_EN
    logic [31:0] mem [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            keys_valid_o <= 1'b0;
            for (int j = 0; j < 32; j++) begin
                mem[j] <= '0;
            end
        end else if (clear_i) begin
            keys_valid_o <= 1'b0;
        end else if (accept) begin
            keys_valid_o <= 1'b0;
        end else if (state == ST_ROUND) begin
            mem[cnt] <= rk_next;
            if (cnt == LAST_RND) begin
                keys_valid_o <= 1'b1;
            end
        end
    end

    assign rd_rk_o = mem[rd_idx_i];
`endif

endmodule

// File: tb/tb_sm4_key_sched.sv
// Self-checking bench for sm4_key_sched: scoreboard of expected round-key strobes.
// Covers reset values, standard vector, back-to-back, clear, async reset, random keys.
// Storage checks are compiled in when SM4_KS_RK_STORE_EN is defined.
module tb_sm4_key_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic [4:0]   rk_idx;
    logic [31:0]  rk;
    logic         done;
`ifdef SM4_KS_RK_STORE_EN
    logic [4:0]   rd_idx;
    logic [31:0]  rd_rk;
    logic         keys_valid;
`endif

    always #5 clk = ~clk;

    sm4_key_sched dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .key_valid_i  (key_valid),
        .key_ready_o  (key_ready),
        .key_i        (key),
`ifdef SM4_KS_RK_STORE_EN
        .rd_idx_i     (rd_idx),
        .rd_rk_o      (rd_rk),
        .keys_valid_o (keys_valid),
`endif
        .busy_o       (busy),
        .rk_valid_o   (rk_valid),
        .rk_idx_o     (rk_idx),
        .rk_o         (rk),
        .done_o       (done)
    );

    localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;

    localparam bit [7:0] SB [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] rk;
        int          cyc;
        logic        done;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] mdl_rk [32];
    logic [31:0] obs_rk [32];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_chk++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp_v, cyc);
        end
    endtask

    // Reference model of the key expansion, written from the algorithm definition.
    function automatic logic [31:0] ck_of(input int i);
        logic [31:0] c;
        for (int j = 0; j < 4; j++) begin
            c[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
        end
        return c;
    endfunction

    task automatic build_exp(input logic [127:0] mk);
        logic [31:0] k [4];
        logic [31:0] x, b, r;
        k[0] = mk[127:96] ^ 32'ha3b1bac6;
        k[1] = mk[95:64]  ^ 32'h56aa3350;
        k[2] = mk[63:32]  ^ 32'h677d9197;
        k[3] = mk[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            x = k[1] ^ k[2] ^ k[3] ^ ck_of(i);
            b = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
            r = k[0] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
            mdl_rk[i] = r;
            k[0] = k[1];
            k[1] = k[2];
            k[2] = k[3];
            k[3] = r;
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard, cycle-exact.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rk_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe", {59'd0, rk_idx}, 64'hffff);
            end else begin
                e = sb_q.pop_front();
                chk("rk_idx", rk_idx, e.idx);
                chk("rk_val", rk, e.rk);
                chk("rk_cycle", cyc, e.cyc);
                chk("done", done, e.done);
                obs_rk[rk_idx] = rk;
            end
        end else if (done) begin
            chk("done_without_strobe", done, 1'b0);
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic offer(input logic [127:0] mk, output int t_acc);
        bit got;
        int waited;
        got       = 1'b0;
        waited    = 0;
        t_acc     = -1;
        key       = mk;
        key_valid = 1'b1;
        while (!got && waited < 100) begin
            @(negedge clk);
            if (key_ready) begin
                got   = 1'b1;
                t_acc = cyc;
            end else begin
                chk("busy_while_not_ready", busy, 1'b1);
                waited++;
            end
            @(posedge clk);
            #1;
        end
        key_valid = 1'b0;
        if (got) begin
            build_exp(mk);
            for (int i = 0; i < 32; i++) begin
                sb_q.push_back('{idx: 5'(i), rk: mdl_rk[i], cyc: t_acc + 2 + i, done: (i == 31)});
            end
        end else begin
            chk("accept_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb_q.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (sb_q.size() != 0) begin
            chk("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_key_ready", key_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rk_valid", rk_valid, 1'b0);
        chk("rst_rk_idx", rk_idx, 5'd0);
        chk("rst_rk", rk, 32'd0);
        chk("rst_done", done, 1'b0);
`ifdef SM4_KS_RK_STORE_EN
        chk("rst_keys_valid", keys_valid, 1'b0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t_a, t_b;
        rst_n     = 1'b1;
        clear     = 1'b0;
        key_valid = 1'b0;
        key       = '0;
`ifdef SM4_KS_RK_STORE_EN
        rd_idx    = '0;
`endif
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Standard vector.
        offer(STD_KEY, t_a);
        drain();
        chk("std_rk0", obs_rk[0], 32'hf12186f9);
        chk("std_rk1", obs_rk[1], 32'h41662b61);
        chk("std_rk31", obs_rk[31], 32'h9124a012);
`ifdef SM4_KS_RK_STORE_EN
        chk("store_keys_valid", keys_valid, 1'b1);
        rd_idx = 5'd0;
        #1 chk("store_rd0", rd_rk, 32'hf12186f9);
        rd_idx = 5'd31;
        #1 chk("store_rd31", rd_rk, 32'h9124a012);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1 rd_idx = 5'(i);
            #1 chk("store_rd", rd_rk, mdl_rk[i]);
        end
        @(posedge clk);
        #1;
`endif

        // Back-to-back: key_valid held high through ROUND.
        offer({$urandom, $urandom, $urandom, $urandom}, t_a);
`ifdef SM4_KS_RK_STORE_EN
        chk("keys_valid_drop", keys_valid, 1'b0);
`endif
        offer({$urandom, $urandom, $urandom, $urandom}, t_b);
        chk("b2b_accept_cycle", t_b, t_a + 33);
        drain();

        // clear_i mid-schedule.
        offer({$urandom, $urandom, $urandom, $urandom}, t_a);
        while (cyc < t_a + 10) begin
            @(posedge clk);
            #1;
        end
        clear     = 1'b1;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        key_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("clr_key_ready", key_ready, 1'b1);
        chk("clr_rk_valid", rk_valid, 1'b0);
        chk("clr_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        // Key offered together with clear in IDLE must not be taken.
        clear     = 1'b1;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        chk("clr_idle_no_accept", busy, 1'b0);
        @(posedge clk);
        #1;
        offer({$urandom, $urandom, $urandom, $urandom}, t_a);
        drain();

        // Asynchronous reset mid-schedule.
        offer({$urandom, $urandom, $urandom, $urandom}, t_a);
        while (cyc < t_a + 20) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) obs_rk[i] = '0;
        offer(STD_KEY, t_a);
        drain();
        chk("rst_std_rk0", obs_rk[0], 32'hf12186f9);
        chk("rst_std_rk31", obs_rk[31], 32'h9124a012);

        // Random keys, back-to-back.
        for (int n = 0; n < 1000; n++) begin
            offer({$urandom, $urandom, $urandom, $urandom}, t_a);
        end
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
